mips_mem_arbiter: RTL and testbench

Arbitrates a single-port, variable-latency unified memory between the pipelined MIPS fetch stage (F) and memory stage (M). Sits between the pipeline datapath and the memory model, replacing the separate instruction and data memories. It generates stall_f and stall_m so the pipeline hazard logic freezes the stages whose access has not completed. Memory-side handshake is req/ready; the access is held stable until ready.

---
 rtl/mips_decls_p.sv | 19 +
 rtl/mem_arb_watchdog.sv | 30 +++
 rtl/mips_mem_arbiter.sv | 134 +++++++++++++
 tb/tb_mips_mem_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_decls_p.sv
// Shared declarations for the MIPS unified-memory arbiter: grant FSM state type,
// watchdog defaults and the word-address helper.
package mips_decls_p;

  localparam int TIMEOUT_DEF = 64;
  localparam int CNT_W_DEF   = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2
  } arb_state_t;

  // Memory is word-addressed; byte offset bits are always presented as zero.
  function automatic logic [31:0] word_addr(input logic [31:0] a);
    return a & ~32'h3;
  endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// Busy-cycle watchdog: counts while enabled, clears on request, and flags the
// terminal count TIMEOUT-1 so a hung memory access can be aborted.
module mem_arb_watchdog
  import mips_decls_p::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_tc) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_tc = (r_cnt == TC_VAL);

endmodule

// File: rtl/mips_mem_arbiter.sv
// Single-port unified memory arbiter between the fetch (F) and memory (M) stages,
// with data-first priority, strict alternation after each access, and a watchdog.
module mips_mem_arbiter
  import mips_decls_p::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ireq_f,
  input  logic [31:0] pc_f,
  output logic [31:0] instr_f,
  output logic        i_done,
  input  logic        memread_m,
  input  logic        memwrite_m,
  input  logic [31:0] aluout_m,
  input  logic [31:0] writedata_m,
  output logic [31:0] readdata_m,
  output logic        d_done,
  output logic        stall_f,
  output logic        stall_m,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        timeout_err
);

  arb_state_t  r_state, w_state_nxt;
  logic [31:0] r_addr, r_wdata, r_instr, r_rdata;
  logic        r_we, r_i_done, r_d_done, r_timeout_err;
  logic        w_dreq, w_busy, w_tc, w_abort, w_complete;
  logic        w_grant_i, w_grant_d;

  assign w_dreq     = memread_m | memwrite_m;
  assign w_busy     = (r_state != IDLE);
  assign w_complete = w_busy & (mem_ready | w_tc);
  // A ready arriving on the terminal cycle still counts as a normal completion.
  assign w_abort    = w_busy & w_tc & ~mem_ready;

  mem_arb_watchdog #(
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) u_watchdog (
    .clk  (clk),
    .reset(reset),
    .i_clr(w_grant_i | w_grant_d | w_complete),
    .i_en (w_busy),
    .o_tc (w_tc)
  );

  // Grant logic: the port just served is never re-granted on its own completion.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_i   = 1'b0;
    w_grant_d   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_dreq) begin
          w_state_nxt = D_BUSY;
          w_grant_d   = 1'b1;
        end else if (ireq_f) begin
          w_state_nxt = I_BUSY;
          w_grant_i   = 1'b1;
        end
      end
      I_BUSY: begin
        if (w_complete) begin
          w_state_nxt = w_dreq ? D_BUSY : IDLE;
          w_grant_d   = w_dreq;
        end
      end
      D_BUSY: begin
        if (w_complete) begin
          w_state_nxt = ireq_f ? I_BUSY : IDLE;
          w_grant_i   = ireq_f;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_we          <= 1'b0;
      r_instr       <= '0;
      r_rdata       <= '0;
      r_i_done      <= 1'b0;
      r_d_done      <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_i_done <= w_complete & (r_state == I_BUSY);
      r_d_done <= w_complete & (r_state == D_BUSY);
      if (w_grant_d) begin
        r_addr  <= word_addr(aluout_m);
        r_we    <= memwrite_m;
        r_wdata <= writedata_m;
      end else if (w_grant_i) begin
        r_addr <= word_addr(pc_f);
        r_we   <= 1'b0;
      end
      if (w_complete && r_state == I_BUSY) begin
        r_instr <= w_abort ? 32'h0 : mem_rdata;
      end
      // Stores and aborted accesses return zero so stale bus data never leaks.
      if (w_complete && r_state == D_BUSY) begin
        r_rdata <= (w_abort || r_we) ? 32'h0 : mem_rdata;
      end
      if (w_abort) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign mem_req     = w_busy;
  assign mem_we      = r_we & w_busy;
  assign mem_addr    = r_addr;
  assign mem_wdata   = r_wdata;
  assign instr_f     = r_instr;
  assign readdata_m  = r_rdata;
  assign i_done      = r_i_done;
  assign d_done      = r_d_done;
  assign timeout_err = r_timeout_err;
  assign stall_f     = ireq_f & ~r_i_done;
  assign stall_m     = w_dreq & ~r_d_done;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench for mips_mem_arbiter: stimulus pushes expected completions into a
// queue, and a negedge monitor pops and checks them whenever a done pulse appears.
module tb_mips_mem_arbiter;

  localparam int TO = 16;

  logic        clk, reset;
  logic        ireq_f, memread_m, memwrite_m, mem_ready;
  logic [31:0] pc_f, aluout_m, writedata_m, mem_rdata;
  logic [31:0] instr_f, readdata_m, mem_addr, mem_wdata;
  logic        i_done, d_done, stall_f, stall_m, mem_req, mem_we, timeout_err;

  typedef struct {
    logic        is_d;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   passed = 0;

  mips_mem_arbiter #(.TIMEOUT(TO), .CNT_W(5)) dut (
    .clk(clk), .reset(reset),
    .ireq_f(ireq_f), .pc_f(pc_f), .instr_f(instr_f), .i_done(i_done),
    .memread_m(memread_m), .memwrite_m(memwrite_m), .aluout_m(aluout_m),
    .writedata_m(writedata_m), .readdata_m(readdata_m), .d_done(d_done),
    .stall_f(stall_f), .stall_m(stall_m),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  task automatic push_exp(input logic d, input logic [31:0] v);
    exp_t t;
    t.is_d = d;
    t.data = v;
    q.push_back(t);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!reset && (i_done || d_done)) begin
      if (q.size() == 0) begin
        check("unexpected_done", {30'b0, i_done, d_done}, 32'h0);
      end else begin
        e = q.pop_front();
        check("done_kind", {31'b0, d_done}, {31'b0, e.is_d});
        check("done_data", e.is_d ? readdata_m : instr_f, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0x00000001 expected 0x00000000");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; ireq_f = 1'b0; memread_m = 1'b0; memwrite_m = 1'b0; mem_ready = 1'b0;
    pc_f = '0; aluout_m = '0; writedata_m = '0; mem_rdata = '0;
    repeat (3) step();
    smp();
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_i_done", i_done, 0);
    check("rst_d_done", d_done, 0);
    check("rst_terr", timeout_err, 0);
    check("rst_instr", instr_f, 0);
    check("rst_rdata", readdata_m, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    reset = 1'b0;
    step();

    // Fetch, zero wait
    ireq_f = 1'b1; pc_f = 32'h40;
    push_exp(1'b0, 32'h20020005);
    smp(); check("t1_stall_f_n", stall_f, 1); check("t1_req_n", mem_req, 0);
    step();
    mem_ready = 1'b1; mem_rdata = 32'h20020005;
    smp(); check("t1_req", mem_req, 1); check("t1_addr", mem_addr, 32'h40);
    check("t1_we", mem_we, 0); check("t1_stall_f_n1", stall_f, 1);
    step();
    ireq_f = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    smp(); check("t1_i_done", i_done, 1); check("t1_idle", mem_req, 0);
    step();
    smp(); check("t1_pulse_end", i_done, 0);
    step();

    // Simultaneous requests: data first, fetch granted with no idle gap
    ireq_f = 1'b1; pc_f = 32'h44;
    memwrite_m = 1'b1; aluout_m = 32'h54; writedata_m = 32'h7;
    push_exp(1'b1, 32'h0);
    push_exp(1'b0, 32'hAAAA5555);
    smp(); check("t2_stall_m", stall_m, 1); check("t2_stall_f", stall_f, 1);
    step();
    mem_ready = 1'b1;
    smp(); check("t2_req", mem_req, 1); check("t2_we", mem_we, 1);
    check("t2_addr", mem_addr, 32'h54); check("t2_wdata", mem_wdata, 32'h7);
    step();
    memwrite_m = 1'b0; mem_rdata = 32'hAAAA5555;
    smp(); check("t2_d_done", d_done, 1); check("t2_nogap_req", mem_req, 1);
    check("t2_i_addr", mem_addr, 32'h44); check("t2_i_we", mem_we, 0);
    step();
    ireq_f = 1'b0; mem_ready = 1'b0;
    smp(); check("t2_i_done", i_done, 1);
    step();
    smp(); check("t2_idle", mem_req, 0);
    step();

    // Load with 3 wait states
    memread_m = 1'b1; aluout_m = 32'h80;
    push_exp(1'b1, 32'h1234);
    smp(); check("t3_stall_n", stall_m, 1);
    step();
    for (int i = 0; i < 3; i++) begin
      smp(); check("t3_wait_req", mem_req, 1); check("t3_wait_stall", stall_m, 1);
      step();
    end
    mem_ready = 1'b1; mem_rdata = 32'h1234;
    smp(); check("t3_stall_n4", stall_m, 1); check("t3_no_done_n4", d_done, 0);
    check("t3_addr", mem_addr, 32'h80);
    step();
    memread_m = 1'b0; mem_ready = 1'b0; mem_rdata = 32'hDEADBEEF;
    smp(); check("t3_d_done", d_done, 1);
    step();
    for (int i = 0; i < 2; i++) begin
      smp(); check("t3_hold", readdata_m, 32'h1234);
      step();
    end

    // Address stability while pc_f changes
    ireq_f = 1'b1; pc_f = 32'h40;
    push_exp(1'b0, 32'h11112222);
    smp();
    step();
    pc_f = 32'h48;
    smp(); check("t4_addr1", mem_addr, 32'h40);
    step();
    smp(); check("t4_addr2", mem_addr, 32'h40);
    step();
    mem_ready = 1'b1; mem_rdata = 32'h11112222;
    smp(); check("t4_addr3", mem_addr, 32'h40);
    step();
    ireq_f = 1'b0; mem_ready = 1'b0;
    smp(); check("t4_i_done", i_done, 1);
    step();

    // Timeout on a load that never completes
    memread_m = 1'b1; aluout_m = 32'h100;
    push_exp(1'b1, 32'h0);
    smp();
    step();
    for (int i = 1; i <= TO; i++) begin
      smp(); check("t5_busy_req", mem_req, 1); check("t5_busy_done", d_done, 0);
      check("t5_busy_terr", timeout_err, 0);
      step();
    end
    memread_m = 1'b0;
    smp(); check("t5_d_done", d_done, 1); check("t5_terr", timeout_err, 1);
    check("t5_idle", mem_req, 0);
    step();
    for (int i = 0; i < 3; i++) begin
      smp(); check("t5_sticky", timeout_err, 1);
      step();
    end

    // Reset in the middle of a store
    memwrite_m = 1'b1; aluout_m = 32'h200; writedata_m = 32'h55;
    smp();
    step();
    reset = 1'b1; memwrite_m = 1'b0;
    smp(); check("t6_busy", mem_req, 1); check("t6_addr", mem_addr, 32'h200);
    step();
    reset = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h9999;
    smp(); check("t6_req", mem_req, 0); check("t6_we", mem_we, 0);
    check("t6_maddr", mem_addr, 0); check("t6_mwdata", mem_wdata, 0);
    check("t6_terr", timeout_err, 0); check("t6_rdata", readdata_m, 0);
    check("t6_instr", instr_f, 0); check("t6_d_done", d_done, 0);
    step();
    mem_ready = 1'b0;
    smp(); check("t6_late_ready_done", d_done, 0); check("t6_late_rdata", readdata_m, 0);
    check("t6_late_req", mem_req, 0);
    step();

    check("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
